// File: rtl/cv32e40p_obi_pkg.sv
// Shared OBI request types and limits for the data-port slice.
package cv32e40p_obi_pkg;

  localparam int OBI_MAX_OUTSTANDING_LIMIT = 4;

  typedef struct packed {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } obi_req_t;

  typedef enum logic {
    REQ_EMPTY = 1'b0,
    REQ_PEND  = 1'b1
  } req_state_e;

  localparam obi_req_t OBI_REQ_RESET = '0;

endpackage

// File: rtl/cv32e40p_obi_req_reg.sv
// Single-entry request holding register between the host and device sides of the slice.
//
// state     | meaning
// REQ_EMPTY | no request held, device request low
// REQ_PEND  | request held and presented to the device until granted
module cv32e40p_obi_req_reg
  import cv32e40p_obi_pkg::*;
(
  input  logic     clk_i,
  input  logic     rst_ni,
  input  logic     capture,
  input  logic     dev_gnt,
  input  obi_req_t req_in,
  output logic     pend,
  output obi_req_t req_out
);

  req_state_e state_q;
  req_state_e state_d;
  obi_req_t   req_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= REQ_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // A grant and a new capture in the same cycle keep the entry occupied.
  always_comb begin
    state_d = state_q;
    case (state_q)
      REQ_EMPTY: begin
        if (capture) begin
          state_d = REQ_PEND;
        end
      end
      REQ_PEND: begin
        if (dev_gnt && !capture) begin
          state_d = REQ_EMPTY;
        end
      end
      default: state_d = REQ_EMPTY;
    endcase
  end

  always_comb begin
    pend = (state_q == REQ_PEND);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      req_q <= OBI_REQ_RESET;
    end else if (capture) begin
      req_q <= req_in;
    end
  end

  assign req_out = req_q;

endmodule

// File: rtl/cv32e40p_obi_slice.sv
// OBI data-port slice: registered request path, outstanding counter, response forwarding.
// Optional macro CV32E40P_OBI_SLICE_RESP_REG_EN registers the response path (1 cycle latency).
module cv32e40p_obi_slice
  import cv32e40p_obi_pkg::*;
#(
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        s_req_i,
  output logic        s_gnt_o,
  input  logic [31:0] s_addr_i,
  input  logic        s_we_i,
  input  logic [3:0]  s_be_i,
  input  logic [31:0] s_wdata_i,
  output logic        s_rvalid_o,
  output logic [31:0] s_rdata_o,
  output logic        m_req_o,
  input  logic        m_gnt_i,
  output logic [31:0] m_addr_o,
  output logic        m_we_o,
  output logic [3:0]  m_be_o,
  output logic [31:0] m_wdata_o,
  input  logic        m_rvalid_i,
  input  logic [31:0] m_rdata_i,
  output logic        protocol_err_o
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

  if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > OBI_MAX_OUTSTANDING_LIMIT) begin : g_bad_param
    $error("MAX_OUTSTANDING out of range 1..%0d", OBI_MAX_OUTSTANDING_LIMIT);
  end

  logic [CNT_W-1:0] cnt_q;
  logic             pend;
  logic             accept;
  logic             resp_ok;
  logic             unsolicited;
  logic             err_q;
  obi_req_t         req_in;
  obi_req_t         req_out;

  assign req_in.addr  = s_addr_i;
  assign req_in.we    = s_we_i;
  assign req_in.be    = s_be_i;
  assign req_in.wdata = s_wdata_i;

  // Grant only from registered state, so a same-cycle response never frees a slot.
  assign s_gnt_o = (!pend || m_gnt_i) && (cnt_q < CNT_MAX);
  assign accept  = s_req_i && s_gnt_o;

  cv32e40p_obi_req_reg u_req_reg (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .capture (accept),
    .dev_gnt (m_gnt_i),
    .req_in  (req_in),
    .pend    (pend),
    .req_out (req_out)
  );

  assign m_req_o   = pend;
  assign m_addr_o  = req_out.addr;
  assign m_we_o    = req_out.we;
  assign m_be_o    = req_out.be;
  assign m_wdata_o = req_out.wdata;

`ifdef CV32E40P_OBI_SLICE_RESP_REG_EN
  logic        rvalid_q;
  logic [31:0] rdata_q;

  // A response still in the output register has not yet retired from cnt_q.
  assign resp_ok = (cnt_q > CNT_W'(rvalid_q));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= m_rvalid_i && resp_ok;
      if (m_rvalid_i && resp_ok) begin
        rdata_q <= m_rdata_i;
      end
    end
  end

  assign s_rvalid_o = rvalid_q;
  assign s_rdata_o  = rdata_q;
`else
  assign resp_ok    = (cnt_q != '0);
  assign s_rvalid_o = m_rvalid_i && resp_ok;
  assign s_rdata_o  = m_rdata_i;
`endif

  assign unsolicited = m_rvalid_i && !resp_ok;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({accept, s_rvalid_o})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_q <= 1'b0;
    end else if (unsolicited) begin
      err_q <= 1'b1;
    end
  end

  assign protocol_err_o = err_q;

endmodule

// File: tb/tb_cv32e40p_obi_slice.sv
// Directed self-checking bench for cv32e40p_obi_slice (MAX_OUTSTANDING=2).
module tb_cv32e40p_obi_slice;

  logic        clk_i;
  logic        rst_ni;
  logic        s_req_i;
  logic        s_gnt_o;
  logic [31:0] s_addr_i;
  logic        s_we_i;
  logic [3:0]  s_be_i;
  logic [31:0] s_wdata_i;
  logic        s_rvalid_o;
  logic [31:0] s_rdata_o;
  logic        m_req_o;
  logic        m_gnt_i;
  logic [31:0] m_addr_o;
  logic        m_we_o;
  logic [3:0]  m_be_o;
  logic [31:0] m_wdata_o;
  logic        m_rvalid_i;
  logic [31:0] m_rdata_i;
  logic        protocol_err_o;

  int n_total = 0;
  int n_bad   = 0;

  cv32e40p_obi_slice #(.MAX_OUTSTANDING(2)) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .s_req_i        (s_req_i),
    .s_gnt_o        (s_gnt_o),
    .s_addr_i       (s_addr_i),
    .s_we_i         (s_we_i),
    .s_be_i         (s_be_i),
    .s_wdata_i      (s_wdata_i),
    .s_rvalid_o     (s_rvalid_o),
    .s_rdata_o      (s_rdata_o),
    .m_req_o        (m_req_o),
    .m_gnt_i        (m_gnt_i),
    .m_addr_o       (m_addr_o),
    .m_we_o         (m_we_o),
    .m_be_o         (m_be_o),
    .m_wdata_o      (m_wdata_o),
    .m_rvalid_i     (m_rvalid_i),
    .m_rdata_i      (m_rdata_i),
    .protocol_err_o (protocol_err_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    #1;
  endtask

  // Back-to-back table, one entry per cycle, bit k = cycle k.
  logic [8:0] b2b_req  = 9'b000111111;
  logic [8:0] b2b_rv   = 9'b110011000;
  logic [8:0] b2b_gnt  = 9'b100110011;
  logic [8:0] b2b_mreq = 9'b001100110;
  int b2b_idx[9]  = '{0, 1, 2, 2, 2, 3, 0, 0, 0};
  int b2b_ridx[9] = '{0, 0, 0, 0, 1, 0, 0, 2, 3};
  int b2b_midx[9] = '{0, 0, 1, 0, 0, 2, 3, 0, 0};

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_ni     = 1'b0;
    s_req_i    = 1'b0;
    s_addr_i   = '0;
    s_we_i     = 1'b0;
    s_be_i     = '0;
    s_wdata_i  = '0;
    m_gnt_i    = 1'b0;
    m_rvalid_i = 1'b0;
    m_rdata_i  = '0;

    repeat (2) cyc();
    #1;
    check("rst_m_req", m_req_o, 0);
    check("rst_m_addr", m_addr_o, 0);
    check("rst_s_rvalid", s_rvalid_o, 0);
    check("rst_s_gnt", s_gnt_o, 1);
    check("rst_err", protocol_err_o, 0);
    rst_ni = 1'b1;
    cyc();

    // single read
    s_req_i = 1'b1; s_addr_i = 32'h1000; s_we_i = 1'b0; s_be_i = 4'hf;
    #1;
    check("rd_s_gnt", s_gnt_o, 1);
    check("rd_m_req_lat", m_req_o, 0);
    cyc();
    s_req_i = 1'b0; m_gnt_i = 1'b1;
    #1;
    check("rd_m_req", m_req_o, 1);
    check("rd_m_addr", m_addr_o, 32'h1000);
    check("rd_m_we", m_we_o, 0);
    cyc();
    m_gnt_i = 1'b0;
    #1;
    check("rd_m_req_done", m_req_o, 0);
    m_rvalid_i = 1'b1; m_rdata_i = 32'hDEADBEEF;
`ifndef CV32E40P_OBI_SLICE_RESP_REG_EN
    #1;
    check("rd_s_rvalid", s_rvalid_o, 1);
    check("rd_s_rdata", s_rdata_o, 32'hDEADBEEF);
    cyc();
    m_rvalid_i = 1'b0;
`else
    cyc();
    m_rvalid_i = 1'b0;
    #1;
    check("rd_s_rvalid", s_rvalid_o, 1);
    check("rd_s_rdata", s_rdata_o, 32'hDEADBEEF);
`endif
    cyc();
    #1;
    check("rd_cnt", 32'(dut.cnt_q), 0);
    check("rd_err", protocol_err_o, 0);

`ifndef CV32E40P_OBI_SLICE_RESP_REG_EN
    // back-to-back writes, device always granting, responses two cycles after grant
    m_gnt_i = 1'b1;
    s_we_i  = 1'b1;
    for (int k = 0; k < 9; k++) begin
      s_req_i    = b2b_req[k];
      s_addr_i   = 32'h2000 + 32'(4 * b2b_idx[k]);
      s_wdata_i  = 32'h11110000 + 32'(b2b_idx[k]);
      m_rvalid_i = b2b_rv[k];
      m_rdata_i  = 32'hA0A00000 + 32'(b2b_ridx[k]);
      #1;
      check($sformatf("b2b_gnt_c%0d", k), s_gnt_o, 32'(b2b_gnt[k]));
      check($sformatf("b2b_mreq_c%0d", k), m_req_o, 32'(b2b_mreq[k]));
      if (b2b_mreq[k]) begin
        check($sformatf("b2b_addr_c%0d", k), m_addr_o, 32'h2000 + 32'(4 * b2b_midx[k]));
        check($sformatf("b2b_wdata_c%0d", k), m_wdata_o, 32'h11110000 + 32'(b2b_midx[k]));
      end
      check($sformatf("b2b_rvalid_c%0d", k), s_rvalid_o, 32'(b2b_rv[k]));
      if (b2b_rv[k]) begin
        check($sformatf("b2b_rdata_c%0d", k), s_rdata_o, 32'hA0A00000 + 32'(b2b_ridx[k]));
      end
      if (k == 5) begin
        check("simul_cnt", 32'(dut.cnt_q), 1);
      end
      cyc();
    end
    s_req_i = 1'b0; m_rvalid_i = 1'b0; m_gnt_i = 1'b0;
    #1;
    check("b2b_cnt_end", 32'(dut.cnt_q), 0);
`endif

    // device stall
    m_gnt_i = 1'b0;
    s_req_i = 1'b1; s_addr_i = 32'h3000; s_wdata_i = 32'h5555AAAA; s_be_i = 4'h5; s_we_i = 1'b1;
    #1;
    check("stall_gnt0", s_gnt_o, 1);
    cyc();
    s_addr_i = 32'h3100; s_wdata_i = 32'h0; s_be_i = 4'hf;
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("stall_mreq_%0d", i), m_req_o, 1);
      check($sformatf("stall_addr_%0d", i), m_addr_o, 32'h3000);
      check($sformatf("stall_wdata_%0d", i), m_wdata_o, 32'h5555AAAA);
      check($sformatf("stall_be_%0d", i), m_be_o, 32'h5);
      check($sformatf("stall_gnt_%0d", i), s_gnt_o, 0);
      cyc();
    end
    m_gnt_i = 1'b1; s_req_i = 1'b0;
    #1;
    check("stall_mreq_gnt", m_req_o, 1);
    cyc();
    m_gnt_i = 1'b0;
    #1;
    check("stall_mreq_off", m_req_o, 0);
    m_rvalid_i = 1'b1; m_rdata_i = 32'h12345678;
    cyc();
    m_rvalid_i = 1'b0;
    cyc();
    #1;
    check("stall_cnt", 32'(dut.cnt_q), 0);

    // unsolicited response
    m_rvalid_i = 1'b1; m_rdata_i = 32'hBAD0BAD0;
    #1;
    check("unsol_rvalid", s_rvalid_o, 0);
    check("unsol_err_pre", protocol_err_o, 0);
    cyc();
    m_rvalid_i = 1'b0; m_rdata_i = 32'h0;
    #1;
    check("unsol_rvalid_post", s_rvalid_o, 0);
    check("unsol_err", protocol_err_o, 1);
    repeat (3) cyc();
    check("unsol_err_hold", protocol_err_o, 1);

    // reset mid-transaction with two outstanding
    s_req_i = 1'b1; s_addr_i = 32'h4000; s_we_i = 1'b1; s_be_i = 4'h3; s_wdata_i = 32'h77;
    cyc();
    m_gnt_i = 1'b1; s_addr_i = 32'h4004;
    #1;
    check("mid_gnt", s_gnt_o, 1);
    cyc();
    m_gnt_i = 1'b0; s_req_i = 1'b0;
    #1;
    check("mid_cnt2", 32'(dut.cnt_q), 2);
    check("mid_mreq", m_req_o, 1);
    check("mid_addr", m_addr_o, 32'h4004);
    #1;
    rst_ni = 1'b0;
    #1;
    check("mid_rst_mreq", m_req_o, 0);
    check("mid_rst_addr", m_addr_o, 0);
    check("mid_rst_we", m_we_o, 0);
    check("mid_rst_be", m_be_o, 0);
    check("mid_rst_wdata", m_wdata_o, 0);
    check("mid_rst_rvalid", s_rvalid_o, 0);
    check("mid_rst_rdata", s_rdata_o, 0);
    check("mid_rst_err", protocol_err_o, 0);
    check("mid_rst_cnt", 32'(dut.cnt_q), 0);
    cyc();
    rst_ni = 1'b1;
    cyc();
    m_rvalid_i = 1'b1; m_rdata_i = 32'h4444;
    #1;
    check("stale_rvalid", s_rvalid_o, 0);
    cyc();
    m_rvalid_i = 1'b0; m_rdata_i = 32'h0;
    #1;
    check("stale_err", protocol_err_o, 1);
    s_req_i = 1'b1; s_addr_i = 32'h5000; s_we_i = 1'b0;
    #1;
    check("post_gnt", s_gnt_o, 1);
    cyc();
    s_req_i = 1'b0;
    #1;
    check("post_mreq", m_req_o, 1);
    check("post_addr", m_addr_o, 32'h5000);
    cyc();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/cv32e40p_obi_slice.md
CV32E40P_OBI_SLICE -- requirements
Module: cv32e40p_obi_slice

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 2, giving the maximum host transactions granted but not yet responded (legal range 1..4).
REQ-002 SHALL have clk_i  input  1  the single clock; all state is on its rising edge.
REQ-003 SHALL have rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have s_req_i  input  1  host (core data port) request.
REQ-005 SHALL have s_gnt_o  output  1  host grant.
REQ-006 SHALL have s_addr_i  input  32, s_we_i  input  1, s_be_i  input  4, s_wdata_i  input  32; these are the host request attributes.
REQ-007 SHALL have s_rvalid_o  output  1 and s_rdata_o  output  32; these are the host response.
REQ-008 SHALL have m_req_o  output  1 and m_gnt_i  input  1; these are the device (memory) handshake.
REQ-009 SHALL have m_addr_o  output  32, m_we_o  output  1, m_be_o  output  4, m_wdata_o  output  32; these are the registered request attributes.
REQ-010 SHALL have m_rvalid_i  input  1 and m_rdata_i  input  32; these are the device response.
REQ-011 SHALL have protocol_err_o  output  1, a sticky flag set on an unsolicited device response.

Function
REQ-012 SHALL hold one request register with states EMPTY and PEND.
REQ-013 SHALL drive s_gnt_o = (state==EMPTY or m_gnt_i) and cnt<MAX_OUTSTANDING.
REQ-014 SHALL capture the host attributes on s_req_i&&s_gnt_o, entering PEND; m_req_o asserts the following cycle (1-cycle request latency).
REQ-015 SHALL assert m_req_o exactly when in PEND, with all m_* attributes constant until m_gnt_i.
REQ-016 SHALL move from PEND to EMPTY on m_gnt_i without a new capture; with m_gnt_i and a new capture in the same cycle, it SHALL stay PEND and load the new attributes (back-to-back, one request per cycle).
REQ-017 SHALL keep an outstanding counter cnt of width $clog2(MAX_OUTSTANDING+1): +1 on host accept, -1 on s_rvalid_o, unchanged when both happen in the same cycle.
REQ-018 SHALL hold s_gnt_o low while cnt==MAX_OUTSTANDING, even when a response occurs in the same cycle (no bypass).
REQ-019 SHALL drop m_rvalid_i arriving with cnt==0 (no device-side transaction outstanding), not forward it, and set protocol_err_o until reset.
REQ-020 SHALL return responses in order; ordering is inherited from OBI in-order completion, with no reordering storage.
REQ-021 SHALL NOT depend on s_req_i for m_req_o in the same cycle; there is no combinational request path from host to device.

Reset
REQ-022 SHALL, on rst_ni low at any time including mid-transaction, asynchronously force state EMPTY, cnt 0, m_req_o 0, m_addr_o/m_we_o/m_be_o/m_wdata_o 0, s_rvalid_o 0, s_rdata_o 0, protocol_err_o 0.
REQ-023 SHALL discard in-flight responses for transactions issued before reset; the response-drop and error rule of REQ-019 applies to them.

Configuration
REQ-024 SHALL honour macro CV32E40P_OBI_SLICE_RESP_REG_EN: when defined, s_rvalid_o/s_rdata_o are registered, giving 1 cycle of response latency, and cnt decrements on the registered valid.
REQ-025 SHALL, without CV32E40P_OBI_SLICE_RESP_REG_EN, drive s_rvalid_o=m_rvalid_i&&cnt!=0 and s_rdata_o=m_rdata_i combinationally (0 cycles of latency).

Structure
REQ-026 SHALL take the typedef obi_req_t {addr[31:0], we, be[3:0], wdata[31:0]} and the constant OBI_MAX_OUTSTANDING_LIMIT=4 from the shared package cv32e40p_obi_pkg.
REQ-027 SHALL implement the EMPTY/PEND holding register as the single sub-module cv32e40p_obi_req_reg; counter and response logic stay in the top-level module.

Verification
REQ-028 Single read: s_req_i with addr=0x1000, gnt immediate -> m_req_o high next cycle with m_addr_o=0x1000; m_rvalid_i with rdata=0xDEADBEEF -> s_rdata_o=0xDEADBEEF (same cycle without the macro, next cycle with it).
REQ-029 Back-to-back: 4 writes with m_gnt_i tied 1 and responses 2 cycles later -> one m_req_o per cycle, and s_gnt_o drops once cnt reaches 2.
REQ-030 Stall: m_gnt_i held 0 for 5 cycles -> m_addr_o/m_wdata_o/m_be_o stable for all 5 cycles, and s_gnt_o stays 0.
REQ-031 Unsolicited response: m_rvalid_i pulsed after reset with no requests -> s_rvalid_o stays 0, protocol_err_o=1 and held until reset.
REQ-032 Reset mid-transaction: rst_ni pulsed low while in PEND with cnt=2 -> all outputs 0 at once, cnt=0, next request accepted normally.
REQ-033 Simultaneous accept and response at cnt=1 -> cnt stays 1 and s_gnt_o stays high on the following cycle.
